// File: rtl/serial_operand_serializer.sv
// serial_operand_serializer: streams a W-bit operand pair one bit per clock
// with first/last framing, accepting back-to-back words without bubbles.
module serial_operand_serializer #(
   parameter int W         = 8,
   parameter bit LSB_FIRST = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         out_valid,
   output logic         out_a,
   output logic         out_b,
   output logic         out_first,
   output logic         out_last
);
   localparam int CW = $clog2(W);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   sh_a_q, sh_a_d, sh_b_q, sh_b_d;
   logic           last, hs;
   assign last      = state_q == SHIFT && cnt_q == CW'(W - 1);
   assign in_ready  = state_q == IDLE || last;
   assign hs        = in_valid && in_ready;
   assign out_valid = state_q == SHIFT;
   assign out_first = out_valid && cnt_q == '0;
   assign out_last  = last;
   // zero fill means the registers are empty again once a word has drained
   assign out_a     = LSB_FIRST ? sh_a_q[0] : sh_a_q[W-1];
   assign out_b     = LSB_FIRST ? sh_b_q[0] : sh_b_q[W-1];
   always_comb begin
      state_d = hs ? SHIFT : (last ? IDLE : state_q);
      cnt_d   = (hs || last) ? '0 : (out_valid ? cnt_q + 1'b1 : cnt_q);
      sh_a_d  = hs ? in_a : (!out_valid ? sh_a_q :
                LSB_FIRST ? {1'b0, sh_a_q[W-1:1]} : {sh_a_q[W-2:0], 1'b0});
      sh_b_d  = hs ? in_b : (!out_valid ? sh_b_q :
                LSB_FIRST ? {1'b0, sh_b_q[W-1:1]} : {sh_b_q[W-2:0], 1'b0});
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sh_a_q  <= '0;
         sh_b_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_a_q  <= sh_a_d;
         sh_b_q  <= sh_b_d;
      end
   end
endmodule
